// File: rtl/alu_bist.sv
// Built-in self-test for a 4-bit, 4-operation ALU. It walks all 1024 {ALUOp,A,B}
// vectors in ascending order and checks the returned C against a reference.
module alu_bist #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [3:0]       A,
  output logic [3:0]       B,
  output logic [1:0]       ALUOp,
  input  logic [3:0]       C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [9:0]       first_fail,
  output logic [3:0]       first_fail_c
);

  localparam int unsigned IDX_W = 10;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_seen;
  logic [3:0]       w_exp;
  logic             w_mis;

  // The index register is the driven vector; it is held at 0 outside RUN.
  assign ALUOp = r_idx[9:8];
  assign A     = r_idx[7:4];
  assign B     = r_idx[3:0];

  // Reference ALU result for the vector currently on the bus.
  always_comb begin
    w_exp = 4'd0;
    case (r_idx[9:8])
      2'b00:   w_exp = r_idx[7:4] + r_idx[3:0];
      2'b01:   w_exp = r_idx[7:4] - r_idx[3:0];
      2'b10:   w_exp = r_idx[7:4] & r_idx[3:0];
      default: w_exp = r_idx[7:4] | r_idx[3:0];
    endcase
  end

  assign w_mis = (r_state == S_RUN) && (C != w_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_seen       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      first_fail   <= '0;
      first_fail_c <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_RUN;
            r_idx        <= '0;
            r_seen       <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_cnt      <= '0;
            first_fail   <= '0;
            first_fail_c <= '0;
          end
        end
        S_RUN: begin
          if (w_mis) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
            if (!r_seen) begin
              r_seen       <= 1'b1;
              first_fail   <= r_idx;
              first_fail_c <= C;
            end
          end
          // The last vector's own result counts towards pass.
          if (r_idx == IDX_LAST) begin
            r_state <= S_DONE;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= !(r_seen || w_mis);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist with a behavioural ALU that can be switched
// between correct, C[0]-stuck-at-0 and add-instead-of-subtract behaviour.
module tb_alu_bist;

  localparam int unsigned ERR_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       A;
  logic [3:0]       B;
  logic [1:0]       ALUOp;
  logic [3:0]       C;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [9:0]       first_fail;
  logic [3:0]       first_fail_c;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  int cyc      = 0;

  alu_bist #(.ERR_W(ERR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .A            (A),
    .B            (B),
    .ALUOp        (ALUOp),
    .C            (C),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .first_fail   (first_fail),
    .first_fail_c (first_fail_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU under test: mode 0 correct, 1 C[0] stuck at 0, 2 op01 computes A+B.
  always_comb begin
    logic [3:0] r;
    case (ALUOp)
      2'b00:   r = A + B;
      2'b01:   r = (mode == 2) ? (A + B) : (A - B);
      2'b10:   r = A & B;
      default: r = A | B;
    endcase
    if (mode == 1) r[0] = 1'b0;
    C = r;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"}, 32'(err_cnt), 0);
    check({tag, "_vec"}, 32'({ALUOp, A, B}), 0);
    check({tag, "_ff"}, 32'(first_fail), 0);
    check({tag, "_ffc"}, 32'(first_fail_c), 0);
  endtask

  // Pulse start for one edge and check the state right after acceptance.
  task automatic start_run(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_acc_busy"}, 32'(busy), 1);
    check({tag, "_acc_done"}, 32'(done), 0);
    check({tag, "_acc_err"}, 32'(err_cnt), 0);
    check({tag, "_acc_pass"}, 32'(pass), 0);
    check({tag, "_acc_vec"}, 32'({ALUOp, A, B}), 0);
  endtask

  // Step until done, bounded; optionally pulse start at cycles 10 and 500.
  task automatic run_to_done(input string tag, input bit pulse_mid);
    cyc = 0;
    while (!done && cyc < 2000) begin
      start = pulse_mid && (cyc == 10 || cyc == 500);
      step();
      cyc++;
      if (cyc == 300) check({tag, "_vec300"}, 32'({ALUOp, A, B}), 300);
    end
    start = 1'b0;
    check({tag, "_done_lat"}, 32'(cyc), 1024);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_vec_done"}, 32'({ALUOp, A, B}), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 0;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b0;
    step();
    check_all_zero("idle");

    // Correct ALU.
    start_run("ok");
    run_to_done("ok", 1'b0);
    check("ok_pass", 32'(pass), 1);
    check("ok_err", 32'(err_cnt), 0);
    check("ok_ff", 32'(first_fail), 0);
    check("ok_ffc", 32'(first_fail_c), 0);

    // Restart straight from DONE with C[0] stuck at 0: 512 mismatches saturate.
    mode = 1;
    start_run("stk");
    run_to_done("stk", 1'b0);
    check("stk_pass", 32'(pass), 0);
    check("stk_err", 32'(err_cnt), 255);
    check("stk_ff", 32'(first_fail), 1);
    check("stk_ffc", 32'(first_fail_c), 0);

    // op01 computes A+B: mismatches for B not in {0,8}; start pulses mid-run ignored.
    mode = 2;
    start_run("sub");
    run_to_done("sub", 1'b1);
    check("sub_pass", 32'(pass), 0);
    check("sub_err", 32'(err_cnt), 224);
    check("sub_ff", 32'(first_fail), 257);
    check("sub_ffc", 32'(first_fail_c), 1);

    // Reset at cycle 100 of a faulty run aborts it.
    mode = 1;
    start_run("abt");
    for (int i = 0; i < 100; i++) step();
    check("abt_vec100", 32'({ALUOp, A, B}), 100);
    check("abt_err100", 32'(err_cnt), 50);
    reset = 1'b1;
    start = 1'b1;
    step();
    check_all_zero("abt_rst");
    reset = 1'b0;
    start = 1'b0;
    step();
    check_all_zero("abt_idle");

    mode = 0;
    start_run("re");
    run_to_done("re", 1'b0);
    check("re_pass", 32'(pass), 1);
    check("re_err", 32'(err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, giving the width of the saturating error counter.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin a self-test run; sampled only in IDLE and DONE.
REQ-005 The block SHALL have port A  output  4  operand A driven to the ALU under test.
REQ-006 The block SHALL have port B  output  4  operand B driven to the ALU under test.
REQ-007 The block SHALL have port ALUOp  output  2  operation select driven to the ALU under test.
REQ-008 The block SHALL have port C  input  4  combinational result returned by the ALU under test.
REQ-009 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-010 The block SHALL have port done  output  1  level, high from run completion until the next accepted start or reset.
REQ-011 The block SHALL have port pass  output  1  valid while done=1; 1 means zero mismatches.
REQ-012 The block SHALL have port err_cnt  output  ERR_W  mismatch count, saturating at 2^ERR_W-1.
REQ-013 The block SHALL have port first_fail  output  10  {ALUOp,A,B} of the first mismatching vector.
REQ-014 The block SHALL have port first_fail_c  output  4  C value observed at the first mismatch.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; transitions: IDLE/DONE --start=1--> RUN; RUN --vector 1023 checked--> DONE; any state --reset--> IDLE.
REQ-016 The vector generator SHALL be a 10-bit index; the driven vector SHALL be {ALUOp,A,B} = index, covering all 1024 combinations in ascending order.
REQ-017 On the edge accepting start, index SHALL clear to 0, err_cnt, first_fail, first_fail_c and pass SHALL clear, done SHALL fall and busy SHALL rise.
REQ-018 In RUN, vector n SHALL be driven during the n-th cycle after the accepting edge (n=0..1023) and C SHALL be compared in that same cycle, with the result registered at the closing edge.
REQ-019 The expected result SHALL be: ALUOp 00 -> (A+B) mod 16; 01 -> (A-B) mod 16, two's-complement wrap; 10 -> A&B; 11 -> A|B.
REQ-020 On each mismatch err_cnt SHALL increment by 1 unless already at 2^ERR_W-1, where it SHALL hold.
REQ-021 first_fail and first_fail_c SHALL be captured only on the first mismatch of a run and held thereafter.
REQ-022 At the edge closing vector 1023 the FSM SHALL enter DONE: busy=0, done=1, pass=1 iff no mismatch occurred in the run, including the final vector.
REQ-023 done SHALL therefore rise exactly 1024 clock edges after the accepting edge.
REQ-024 start SHALL be ignored while in RUN; start held high in DONE SHALL immediately start a new run.
REQ-025 In IDLE and DONE, A, B and ALUOp SHALL be driven to 0.
REQ-026 The index SHALL NOT wrap into a second pass; after 1023 it SHALL stop at DONE.

Reset
REQ-027 With reset=1 at an edge, all outputs SHALL become 0 (A, B, ALUOp, busy, done, pass, err_cnt, first_fail, first_fail_c), the index SHALL become 0 and the state SHALL become IDLE.
REQ-028 Reset SHALL take priority over start and abort a run in progress, discarding partial results.

Verification
REQ-029 Correct ALU model, 1-cycle start pulse -> busy 1024 cycles, then done=1, pass=1, err_cnt=0, first_fail=0, first_fail_c=0.
REQ-030 ALU with C[0] stuck at 0 -> done after 1024 cycles, pass=0, err_cnt=255 (512 mismatches saturated), first_fail=10'd1, first_fail_c=4'd0.
REQ-031 ALU computing A+B for ALUOp 01 -> pass=0, err_cnt=224, first_fail=10'd257 (op01, A=0, B=1), first_fail_c=4'd1.
REQ-032 Reset asserted at cycle 100 of a run -> next edge: all outputs 0, IDLE; a later start with a correct ALU -> pass=1, err_cnt=0.
REQ-033 start pulsed at cycles 10 and 500 of a run -> no restart, done still 1024 edges after the first start; start pulsed again in DONE -> done=0 and busy=1 at the next edge.
